// File: rtl/histogram_accumulator_pkg.sv
// Shared histogram types and constants, also used by the derivative stage.
package hist_pkg;

   localparam int HIST_BINS    = 256;
   localparam int HIST_PIX_W   = 8;
   localparam int HIST_COUNT_W = 16;

   typedef logic [HIST_COUNT_W-1:0] hist_count_t;

   typedef enum logic [0:0] {
      S_ACCUM   = 1'b0,
      S_PRESENT = 1'b1
   } hist_state_e;

endpackage

// File: rtl/histogram_accumulator_if.sv
// Pixel-in and histogram-out handshake bundle for histogram_accumulator.
interface histogram_accumulator_if #(
   parameter int BINS    = hist_pkg::HIST_BINS,
   parameter int PIX_W   = hist_pkg::HIST_PIX_W,
   parameter int COUNT_W = hist_pkg::HIST_COUNT_W
) ();

   // pixel stream side
   logic [PIX_W-1:0]   i_pixel;
   logic               i_pixel_valid;
   logic               i_pixel_last;
   logic               o_pixel_ready;

   // histogram presentation side
   logic [COUNT_W-1:0] o_histogram [BINS-1:0];
   logic               o_valid;
   logic               i_ready;
   logic               o_saturated;
   logic [31:0]        o_pixel_count;

   // view of the accumulator itself
   modport slave (
      input  i_pixel, i_pixel_valid, i_pixel_last, i_ready,
      output o_pixel_ready, o_histogram, o_valid, o_saturated, o_pixel_count
   );

   // view of whoever feeds pixels and consumes the histogram
   modport master (
      output i_pixel, i_pixel_valid, i_pixel_last, i_ready,
      input  o_pixel_ready, o_histogram, o_valid, o_saturated, o_pixel_count
   );

endinterface

// File: rtl/histogram_accumulator_bin_counter.sv
// One saturating histogram bin with synchronous clear.
module hist_bin_counter
   import hist_pkg::*;
#(
   parameter int COUNT_W = HIST_COUNT_W
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_inc,
   input  logic               i_clr,
   output logic [COUNT_W-1:0] o_count,
   output logic               o_sat_hit
);

   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

   logic [COUNT_W-1:0] count_q, count_d;

   // Next count: clear wins, otherwise increment unless already all-ones.
   always_comb begin
      count_d = count_q;
      if (i_clr) begin
         count_d = '0;
      end else if (i_inc && (count_q != COUNT_MAX)) begin
         count_d = count_q + COUNT_W'(1);
      end
   end

   // Bin register.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_count   = count_q;
   // An increment that lands on a full bin is the saturation event.
   assign o_sat_hit = i_inc && (count_q == COUNT_MAX);

endmodule

// File: rtl/histogram_accumulator.sv
// Frame histogram builder: accumulates pixels, then presents the bins until taken.
module histogram_accumulator
   import hist_pkg::*;
#(
   parameter int BINS    = HIST_BINS,   // must equal 2**PIX_W
   parameter int PIX_W   = HIST_PIX_W,
   parameter int COUNT_W = HIST_COUNT_W
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   histogram_accumulator_if.slave  bus
);

   localparam logic [0:0]  ST_ACCUM   = 1'(S_ACCUM);
   localparam logic [0:0]  ST_PRESENT = 1'(S_PRESENT);
   localparam logic [31:0] PIX_CNT_MAX = '1;

   logic [0:0]   state_q, state_d;
   logic [31:0]  pix_cnt_q, pix_cnt_d;
   logic         sat_q, sat_d;

   logic         accept;
   logic         clear;
   logic [BINS-1:0] sat_hit;

   // Each bin only ever sees its own increment, so back-to-back hits on the
   // same bin are a plain register increment with no pipeline hazard.
   assign accept = (state_q == ST_ACCUM) && bus.i_pixel_valid;
   assign clear  = (state_q == ST_PRESENT) && bus.i_ready;

   generate
      for (genvar gi = 0; gi < BINS; gi++) begin : g_bin
         logic [COUNT_W-1:0] bin_count;

         hist_bin_counter #(
            .COUNT_W (COUNT_W)
         ) u_bin (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_inc     (accept && (bus.i_pixel == PIX_W'(gi))),
            .i_clr     (clear),
            .o_count   (bin_count),
            .o_sat_hit (sat_hit[gi])
         );

         assign bus.o_histogram[gi] = bin_count;
      end
   endgenerate

   // Frame FSM, pixel counter and sticky saturation flag.
   always_comb begin
      state_d   = state_q;
      pix_cnt_d = pix_cnt_q;
      sat_d     = sat_q;
      if (clear) begin
         state_d   = ST_ACCUM;
         pix_cnt_d = '0;
         sat_d     = 1'b0;
      end else if (accept) begin
         if (pix_cnt_q != PIX_CNT_MAX) begin
            pix_cnt_d = pix_cnt_q + 32'd1;
         end
         if (|sat_hit) begin
            sat_d = 1'b1;
         end
         if (bus.i_pixel_last) begin
            state_d = ST_PRESENT;
         end
      end
   end

   // Control registers.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= ST_ACCUM;
         pix_cnt_q <= '0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pix_cnt_q <= pix_cnt_d;
         sat_q     <= sat_d;
      end
   end

   assign bus.o_pixel_ready = (state_q == ST_ACCUM);
   assign bus.o_valid       = (state_q == ST_PRESENT);
   assign bus.o_saturated   = sat_q;
   assign bus.o_pixel_count = pix_cnt_q;

endmodule
